lp_clk_seq: RTL and testbench
=============================

# lp_clk_seq

Power-up/power-down sequencer for the low-power quadrature clock divider. It owns the divider's active-low reset, the clock-gate enable on the divided clk0/clk90 outputs, and the reset of the divided-clock domain. Software or a power manager requests divided clocks over a four-phase req/ack handshake. The sequencer orders bring-up as divider reset release, lock wait, gate enable, domain reset release, and bring-down in the reverse order. It runs entirely on the fast input clock.

## Interface
Parameters:
- LOCK_CYCLES, 8: cycles the divider runs out of reset before its outputs are gated on.
- RST_HOLD, 4: cycles domain reset is held after gate enable.
- DRAIN_CYCLES, 4: cycles domain reset is held before the gate closes on bring-down.
- CNT_W, 8: counter width. Each cycle parameter must be in the range 1..2^CNT_W; the implementation elaborates with an error otherwise.

Ports:
- clk_i, input, 1: fast input clock; also drives the divider.
- rst_i, input, 1: reset, asynchronous, active-high.
- req_i, input, 1: request divided clocks on; level, four-phase.
- ack_o, output, 1: divided clocks running and domain out of reset.
- div_rst_no, output, 1: to the divider reset input. 0 holds the divider in reset.
- gate_en_o, output, 1: enable for the clock gates on clk0/clk90.
- core_rst_o, output, 1: active-high reset to the divided-clock domain.
- busy_o, output, 1: a sequence is in progress.
- state_o, output, 3: current state encoding, for debug.

## Operation
- States and encodings:
  - OFF=0
  - WAKE=1
  - GATE=2
  - RUN=3
  - QUIESCE=4
  - STOP=5
  - Codes 6 and 7 are illegal and go to STOP on the next edge.
- Output decode. All outputs are registered and change on the same edge as the state.
  - OFF: div_rst_no=0, gate_en_o=0, core_rst_o=1, ack_o=0.
  - WAKE: div_rst_no=1, gate=0, core_rst=1, ack=0.
  - GATE: div_rst_no=1, gate=1, core_rst=1, ack=0.
  - RUN: div_rst_no=1, gate=1, core_rst=0, ack=1.
  - QUIESCE: div_rst_no=1, gate=1, core_rst=1, ack=1.
  - STOP: div_rst_no=0, gate=0, core_rst=1, ack=1.
- busy_o=1 in WAKE, GATE, QUIESCE and STOP.
- Down counter (CNT_W bits):
  - On entry to WAKE, GATE or QUIESCE it loads the corresponding parameter minus 1.
  - It decrements each cycle in those states.
  - The state exits on the edge where the counter is 0.
- Transitions:
  - OFF -> WAKE when req_i=1.
  - WAKE -> GATE when count=0. WAKE -> STOP if req_i=0, aborting before the gate ever opens.
  - GATE -> RUN when count=0. GATE -> QUIESCE if req_i=0.
  - RUN -> QUIESCE when req_i=0.
  - QUIESCE -> STOP when count=0. req_i is ignored.
  - STOP -> OFF unconditionally after 1 cycle.
- Abort checks take priority over count expiry in the same cycle.
- Four-phase rule:
  - ack_o falls only on entry to OFF.
  - A req_i reasserted during QUIESCE or STOP does not cancel the down sequence. The next bring-up starts from OFF on the cycle after OFF is entered, if req_i is still 1.
- Invariants, checked every cycle:
  - gate_en_o=1 implies div_rst_no=1.
  - core_rst_o=0 implies gate_en_o=1.
  - gate_en_o never rises in the same cycle div_rst_no rises.

## Timing
- Reset (rst_i=1, asynchronous):
  - state=OFF, counter=0.
  - div_rst_no=0, gate_en_o=0, core_rst_o=1, ack_o=0, busy_o=0, state_o=0.
  - Deassertion of rst_i is synchronised externally.
- Reset mid-operation from any state returns immediately to the OFF outputs with no drain.
- Bring-up latency. req_i=1 is sampled at edge 0 in OFF:
  - WAKE from edge 0.
  - GATE from edge LOCK_CYCLES.
  - RUN and ack_o=1 from edge LOCK_CYCLES+RST_HOLD. With defaults this is edge 12.
- Bring-down latency. req_i=0 is sampled at edge 0 in RUN:
  - QUIESCE from edge 0.
  - STOP from edge DRAIN_CYCLES.
  - OFF and ack_o=0 from edge DRAIN_CYCLES+1. With defaults this is edge 5.
- Parameters at 1 give single-cycle WAKE, GATE and QUIESCE states.
- No combinational path from req_i to any output.

## Test plan
- Reset, then req_i=1 held: state_o steps 0 -> 1 (edge 0) -> 2 (edge 8) -> 3 (edge 12). ack_o=1 at edge 12; gate_en_o=1 at edge 8; core_rst_o=0 at edge 12.
- From RUN, req_i=0: QUIESCE for 4 cycles, STOP for 1 cycle, then OFF. ack_o=0 at edge 5; gate_en_o=0 and div_rst_no=0 at edge 4.
- Abort in WAKE: drop req_i at edge 3 -> STOP at edge 3, OFF at edge 4. gate_en_o stays 0 throughout. Abort in GATE at edge 10 -> QUIESCE for 4 cycles, then STOP, then OFF.
- Re-request during QUIESCE: req_i toggles 0 -> 1 at drain cycle 2 -> down sequence completes to OFF, then WAKE on the next edge. ack_o shows exactly one low cycle.
- Assert rst_i asynchronously mid-RUN, between clock edges -> all outputs at reset values before the next edge. After release with req_i=1, the full 12-cycle bring-up repeats.
- Parameters LOCK_CYCLES=RST_HOLD=DRAIN_CYCLES=1: ack_o rises at edge 2, falls 2 edges after req_i drops. Invariant assertions hold over 10k cycles of random req_i.

Source files
------------

// File: rtl/lp_clk_seq_if.sv
// Purpose: request/acknowledge and control bundle between a power manager and lp_clk_seq.
// Latency: wires only; all timing is owned by the sequencer.
// Backpressure: four-phase req/ack level handshake, no credits.
interface lp_clk_seq_if;
  logic       req_i;
  logic       ack_o;
  logic       div_rst_no;
  logic       gate_en_o;
  logic       core_rst_o;
  logic       busy_o;
  logic [2:0] state_o;

  // Requester side: raises/drops req, observes everything else.
  modport master (
    output req_i,
    input  ack_o, div_rst_no, gate_en_o, core_rst_o, busy_o, state_o
  );

  // Sequencer side.
  modport slave (
    input  req_i,
    output ack_o, div_rst_no, gate_en_o, core_rst_o, busy_o, state_o
  );
endinterface

// File: rtl/lp_clk_seq.sv
// Purpose: orders divider reset, clock-gate enable and divided-domain reset for the quadrature divider.
// Latency: ack after LOCK_CYCLES+RST_HOLD edges on bring-up; ack drops DRAIN_CYCLES+1 edges after req falls.
// Backpressure: four-phase handshake; a req change mid-sequence is honoured only at the defined abort points.
module lp_clk_seq #(
  parameter int LOCK_CYCLES  = 8,
  parameter int RST_HOLD     = 4,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  lp_clk_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_WAKE    = 3'd1,
    S_GATE    = 3'd2,
    S_RUN     = 3'd3,
    S_QUIESCE = 3'd4,
    S_STOP    = 3'd5
  } state_t;

  typedef struct packed {
    logic ack;
    logic div_rst_n;
    logic gate_en;
    logic core_rst;
    logic busy;
  } outs_t;

  localparam longint MAX_CYC = longint'(1) << CNT_W;

  // Reject cycle counts the down counter cannot represent.
  if (LOCK_CYCLES < 1 || longint'(LOCK_CYCLES) > MAX_CYC) begin : g_bad_lock
    $error("lp_clk_seq: LOCK_CYCLES out of range 1..2^CNT_W");
  end
  if (RST_HOLD < 1 || longint'(RST_HOLD) > MAX_CYC) begin : g_bad_hold
    $error("lp_clk_seq: RST_HOLD out of range 1..2^CNT_W");
  end
  if (DRAIN_CYCLES < 1 || longint'(DRAIN_CYCLES) > MAX_CYC) begin : g_bad_drain
    $error("lp_clk_seq: DRAIN_CYCLES out of range 1..2^CNT_W");
  end

  localparam logic [CNT_W-1:0] LOCK_LD  = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Output pattern of each state; registered alongside the state so no output
  // has a combinational path from req_i.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    case (s)
      S_OFF:     o = '{ack: 1'b0, div_rst_n: 1'b0, gate_en: 1'b0, core_rst: 1'b1, busy: 1'b0};
      S_WAKE:    o = '{ack: 1'b0, div_rst_n: 1'b1, gate_en: 1'b0, core_rst: 1'b1, busy: 1'b1};
      S_GATE:    o = '{ack: 1'b0, div_rst_n: 1'b1, gate_en: 1'b1, core_rst: 1'b1, busy: 1'b1};
      S_RUN:     o = '{ack: 1'b1, div_rst_n: 1'b1, gate_en: 1'b1, core_rst: 1'b0, busy: 1'b0};
      S_QUIESCE: o = '{ack: 1'b1, div_rst_n: 1'b1, gate_en: 1'b1, core_rst: 1'b1, busy: 1'b1};
      S_STOP:    o = '{ack: 1'b1, div_rst_n: 1'b0, gate_en: 1'b0, core_rst: 1'b1, busy: 1'b1};
      default:   o = '{ack: 1'b0, div_rst_n: 1'b0, gate_en: 1'b0, core_rst: 1'b1, busy: 1'b0};
    endcase
    return o;
  endfunction

  state_t           state;
  outs_t            outs;
  logic [CNT_W-1:0] cnt;

  // Sequencer FSM: req drop aborts take priority over counter expiry; the
  // counter loads on entry to each timed state and the state exits when it hits 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_OFF;
      cnt   <= '0;
      outs  <= decode(S_OFF);
    end else begin
      case (state)
        S_OFF: begin
          if (bus.req_i) begin
            state <= S_WAKE;
            cnt   <= LOCK_LD;
            outs  <= decode(S_WAKE);
          end
        end
        S_WAKE: begin
          if (!bus.req_i) begin
            // Gate never opened, so there is nothing to drain.
            state <= S_STOP;
            outs  <= decode(S_STOP);
          end else if (cnt == '0) begin
            state <= S_GATE;
            cnt   <= HOLD_LD;
            outs  <= decode(S_GATE);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_GATE: begin
          if (!bus.req_i) begin
            state <= S_QUIESCE;
            cnt   <= DRAIN_LD;
            outs  <= decode(S_QUIESCE);
          end else if (cnt == '0) begin
            state <= S_RUN;
            outs  <= decode(S_RUN);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_RUN: begin
          if (!bus.req_i) begin
            state <= S_QUIESCE;
            cnt   <= DRAIN_LD;
            outs  <= decode(S_QUIESCE);
          end
        end
        S_QUIESCE: begin
          // A re-raised req cannot cancel the drain; it is picked up from OFF.
          if (cnt == '0) begin
            state <= S_STOP;
            outs  <= decode(S_STOP);
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_STOP: begin
          state <= S_OFF;
          outs  <= decode(S_OFF);
        end
        default: begin
          state <= S_STOP;
          outs  <= decode(S_STOP);
        end
      endcase
    end
  end

  assign bus.ack_o      = outs.ack;
  assign bus.div_rst_no = outs.div_rst_n;
  assign bus.gate_en_o  = outs.gate_en;
  assign bus.core_rst_o = outs.core_rst;
  assign bus.busy_o     = outs.busy;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_lp_clk_seq.sv
// Purpose: checks lp_clk_seq at default and all-ones timing against an elapsed-time model.
// Latency: model is evaluated at each rising edge, outputs sampled 1 ns later.
// Backpressure: none; req is driven directly by the bench.
`timescale 1ns/1ps
module tb_lp_clk_seq;

  logic clk = 1'b0;
  logic rst;
  logic req;

  always #5 clk = ~clk;

  lp_clk_seq_if bus_a ();
  lp_clk_seq_if bus_b ();

  assign bus_a.req_i = req;
  assign bus_b.req_i = req;

  lp_clk_seq #(.LOCK_CYCLES(8), .RST_HOLD(4), .DRAIN_CYCLES(4), .CNT_W(8)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  lp_clk_seq #(.LOCK_CYCLES(1), .RST_HOLD(1), .DRAIN_CYCLES(1), .CNT_W(8)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus cycles elapsed in it.
  localparam int P_OFF = 0, P_UP = 1, P_RUN = 2, P_DRAIN = 3, P_STOP = 4;
  localparam int LOCK_M  [2] = '{8, 1};
  localparam int HOLD_M  [2] = '{4, 1};
  localparam int DRAIN_M [2] = '{4, 1};
  localparam logic [7:0] RST_VEC = 8'b000_00010;
  int ph [2];
  int t  [2];

  // Packed view: {state[2:0], ack, div_rst_n, gate_en, core_rst, busy}.
  function automatic logic [7:0] act_vec(input int k);
    if (k == 0)
      return {bus_a.state_o, bus_a.ack_o, bus_a.div_rst_no, bus_a.gate_en_o, bus_a.core_rst_o, bus_a.busy_o};
    return {bus_b.state_o, bus_b.ack_o, bus_b.div_rst_no, bus_b.gate_en_o, bus_b.core_rst_o, bus_b.busy_o};
  endfunction

  function automatic logic [7:0] exp_vec(input int k);
    logic [2:0] s;
    logic [4:0] o;
    case (ph[k])
      P_OFF:   s = 3'd0;
      P_UP:    s = (t[k] < LOCK_M[k]) ? 3'd1 : 3'd2;
      P_RUN:   s = 3'd3;
      P_DRAIN: s = 3'd4;
      default: s = 3'd5;
    endcase
    case (s)
      3'd0:    o = 5'b00010;
      3'd1:    o = 5'b01011;
      3'd2:    o = 5'b01111;
      3'd3:    o = 5'b11100;
      3'd4:    o = 5'b11111;
      default: o = 5'b10011;
    endcase
    return {s, o};
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        ph[k] = P_OFF;
        t[k]  = 0;
      end else begin
        case (ph[k])
          P_OFF: if (req) begin ph[k] = P_UP; t[k] = 0; end
          P_UP: begin
            if (!req) begin
              if (t[k] < LOCK_M[k]) ph[k] = P_STOP;
              else begin ph[k] = P_DRAIN; t[k] = 0; end
            end else begin
              t[k] = t[k] + 1;
              if (t[k] == LOCK_M[k] + HOLD_M[k]) ph[k] = P_RUN;
            end
          end
          P_RUN: if (!req) begin ph[k] = P_DRAIN; t[k] = 0; end
          P_DRAIN: begin
            t[k] = t[k] + 1;
            if (t[k] == DRAIN_M[k]) ph[k] = P_STOP;
          end
          default: ph[k] = P_OFF;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== RST_VEC) begin
          bad++;
          $display("FAIL reset dut%0d cyc=%0d got=%b want=%b", k, i, act_vec(k), RST_VEC);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    req = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL bringup dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      if (i == 0 || i == 7 || i == 8 || i == 11 || i == 12) begin
        total++;
        if (bus_a.state_o !== ((i < 8) ? 3'd1 : (i < 12) ? 3'd2 : 3'd3)) begin
          bad++;
          $display("FAIL bringup_state edge=%0d got=%0d", i, bus_a.state_o);
        end
        total++;
        if (bus_a.gate_en_o !== (i >= 8) || bus_a.ack_o !== (i >= 12) || bus_a.core_rst_o !== (i < 12)) begin
          bad++;
          $display("FAIL bringup_outs edge=%0d gate=%b ack=%b core_rst=%b", i, bus_a.gate_en_o, bus_a.ack_o, bus_a.core_rst_o);
        end
      end
      if (i == 1 || i == 2) begin
        total++;
        if (bus_b.ack_o !== (i == 2)) begin
          bad++;
          $display("FAIL bringup_min_ack edge=%0d got=%b want=%b", i, bus_b.ack_o, (i == 2));
        end
      end
    end
  endtask

  task automatic test_bringdown();
    req = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL bringdown dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      total++;
      if (bus_a.ack_o !== (i < 5) || bus_a.gate_en_o !== (i < 4) || bus_a.div_rst_no !== (i < 4)) begin
        bad++;
        $display("FAIL bringdown_outs edge=%0d ack=%b gate=%b div_rst_n=%b", i, bus_a.ack_o, bus_a.gate_en_o, bus_a.div_rst_no);
      end
      if (i <= 2) begin
        total++;
        if (bus_b.ack_o !== (i < 2)) begin
          bad++;
          $display("FAIL bringdown_min_ack edge=%0d got=%b want=%b", i, bus_b.ack_o, (i < 2));
        end
      end
    end
  endtask

  task automatic test_abort_wake();
    req = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i == 3) req = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL abort_wake dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      total++;
      if (bus_a.gate_en_o !== 1'b0) begin
        bad++;
        $display("FAIL abort_wake_gate edge=%0d got=%b want=0", i, bus_a.gate_en_o);
      end
      if (i == 3 || i == 4) begin
        total++;
        if (bus_a.state_o !== ((i == 3) ? 3'd5 : 3'd0)) begin
          bad++;
          $display("FAIL abort_wake_state edge=%0d got=%0d", i, bus_a.state_o);
        end
      end
    end
  endtask

  task automatic test_abort_gate();
    req = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i == 10) req = 1'b0;
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL abort_gate dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      if (i >= 9 && i <= 15) begin
        total++;
        if (bus_a.state_o !== ((i == 9) ? 3'd2 : (i <= 13) ? 3'd4 : (i == 14) ? 3'd5 : 3'd0)) begin
          bad++;
          $display("FAIL abort_gate_state edge=%0d got=%0d", i, bus_a.state_o);
        end
      end
    end
  endtask

  task automatic test_requeue();
    int off_cnt;
    req = 1'b1;
    for (int i = 0; i <= 12; i++) step();
    req = 1'b0;
    off_cnt = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i == 2) req = 1'b1;
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL requeue dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      if (bus_a.state_o == 3'd0) off_cnt++;
      if (i >= 4 && i <= 6) begin
        total++;
        if (bus_a.state_o !== ((i == 4) ? 3'd5 : (i == 5) ? 3'd0 : 3'd1)) begin
          bad++;
          $display("FAIL requeue_state edge=%0d got=%0d", i, bus_a.state_o);
        end
      end
    end
    total++;
    if (off_cnt != 1) begin
      bad++;
      $display("FAIL requeue_off_cycles got=%0d want=1", off_cnt);
    end
    req = 1'b0;
    for (int i = 0; i < 12; i++) step();
  endtask

  task automatic test_async_reset();
    req = 1'b1;
    for (int i = 0; i <= 12; i++) step();
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++;
      if (act_vec(k) !== RST_VEC) begin
        bad++;
        $display("FAIL async_reset dut%0d got=%b want=%b", k, act_vec(k), RST_VEC);
      end
    end
    step();
    rst = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (act_vec(k) !== exp_vec(k)) begin
          bad++;
          $display("FAIL rebringup dut%0d edge=%0d got=%b want=%b", k, i, act_vec(k), exp_vec(k));
        end
      end
      if (i == 11 || i == 12) begin
        total++;
        if (bus_a.ack_o !== (i == 12)) begin
          bad++;
          $display("FAIL rebringup_ack edge=%0d got=%b want=%b", i, bus_a.ack_o, (i == 12));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    logic       pg [2];
    logic       pd [2];
    int         hold;
    for (int k = 0; k < 2; k++) begin
      v = act_vec(k);
      pg[k] = v[2];
      pd[k] = v[3];
    end
    hold = 0;
    for (int i = 0; i < 10000; i++) begin
      if (hold == 0) begin
        req  = ($urandom_range(0, 1) == 1);
        hold = $urandom_range(1, 20);
      end
      hold--;
      step();
      for (int k = 0; k < 2; k++) begin
        v = act_vec(k);
        total++;
        if (v !== exp_vec(k)) begin
          bad++;
          $display("FAIL random dut%0d cyc=%0d got=%b want=%b", k, i, v, exp_vec(k));
        end
        total++;
        if (v[2] && !v[3]) begin
          bad++;
          $display("FAIL inv_gate_div dut%0d cyc=%0d gate=%b div_rst_n=%b", k, i, v[2], v[3]);
        end
        total++;
        if (!v[1] && !v[2]) begin
          bad++;
          $display("FAIL inv_core_gate dut%0d cyc=%0d core_rst=%b gate=%b", k, i, v[1], v[2]);
        end
        total++;
        if (v[2] && !pg[k] && v[3] && !pd[k]) begin
          bad++;
          $display("FAIL inv_same_rise dut%0d cyc=%0d gate=1 div_rst_n=1 both rose", k, i);
        end
        pg[k] = v[2];
        pd[k] = v[3];
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ph[k] = P_OFF;
      t[k]  = 0;
    end
    test_reset();
    test_bringup();
    test_bringdown();
    test_abort_wake();
    test_abort_gate();
    test_requeue();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
